mms_seq: RTL and testbench
==========================

Name: mms_seq

Overview:
- Sequential max/min selector. Accepts one 8-bit number per cycle over a valid/ready handshake. After FRAME_LEN accepted numbers it presents the frame's max or min value and that value's position in the frame.
- It is the streaming counterpart of the combinational MMS trees. Producers that deliver numbers serially use it instead of building a FRAME_LEN-wide parallel tree.
- Result leaves on a second valid/ready handshake.

Parameters:
- DATA_W, 8, width of each number and of result.
- FRAME_LEN, 4, numbers per frame; legal range 2..256.
- IDX_W, 2, width of result_idx; must equal ceil(log2(FRAME_LEN)).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  number/select valid this cycle.
- in_ready  output  1  block can accept a number this cycle.
- select  input  1  0 = max, 1 = min; sampled only on the first number of a frame.
- number  input  DATA_W  input number.
- out_valid  output  1  result/result_idx valid.
- out_ready  input  1  consumer takes result this cycle.
- result  output  DATA_W  selected max/min of the frame.
- result_idx  output  IDX_W  0-based frame position of result.

Behaviour:
- Clock and reset are decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset value of every output and state register:
  - state = IDLE, cnt = 0.
  - result = 0, result_idx = 0, out_valid = 0, in_ready = 1 (combinational from state).
- A number is accepted when in_valid && in_ready at the rising edge.
- State machine, states IDLE, ACCUM, DONE:
  - IDLE: in_ready = 1. On accept: best <= number, best_idx <= 0, sel_q <= select, cnt <= 1, go to ACCUM.
  - ACCUM: in_ready = 1. On accept, number replaces best only on strict improvement:
    - sel_q = 0: replace if number > best.
    - sel_q = 1: replace if number < best.
    - On replace, best_idx <= cnt. Then cnt <= cnt + 1.
    - If the accepted number is number FRAME_LEN-1 (0-based), go to DONE, using the post-compare best.
  - DONE: in_ready = 0, out_valid = 1, result = best, result_idx = best_idx, all held stable. On out_ready: go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises the cycle after the last number is accepted.
- Minimum frame period is FRAME_LEN + 1 cycles when out_ready is tied high. There is no overlap of consecutive frames.
- Ties: the earliest index wins.
- select is ignored after the first number of a frame; a mid-frame change has no effect.
- in_valid low mid-frame (bubble): state and cnt hold; no timeout.
- in_valid asserted in DONE: not accepted (in_ready = 0). The producer must hold its data.
- Reset mid-frame or in DONE aborts the frame immediately. The partial result is discarded and the next frame starts at index 0.
- Comparisons are unsigned unless the optional feature is compiled in.

Optional Feature:
- Macro: MMS_SEQ_SIGNED_EN.
- Defined: number and best are compared as two's-complement signed values.
- Undefined: unsigned comparison.
- Handshake, timing and tie rules are identical in both builds.

Decomposition:
- Package mms_pkg holds:
  - constants SEL_MAX = 1'b0 and SEL_MIN = 1'b1;
  - state enum/localparams for IDLE, ACCUM, DONE.
- One sub-module, mms_cmp_sel: combinational compare-and-select.
  - Inputs: select, cand, cand_idx, best, best_idx.
  - Outputs: new best, new best_idx.
  - Strict-improvement rule and the signed/unsigned macro live here.

Test Plan:
- Max, FRAME_LEN = 4: 10, 200, 55, 199 with select = 0, out_ready = 1 → result = 200, result_idx = 1. out_valid is high exactly 1 cycle after the 4th accept, for 1 cycle.
- Min with tie: 7, 3, 3, 9 with select = 1 → result = 3, result_idx = 1 (earliest wins).
- Mid-frame select change: first number 5 with select = 0, then 9, 2, 4 with select = 1 → result = 9, result_idx = 1.
- Backpressure plus bubbles: in_valid gaps of 2 cycles between numbers 1, 2, 3, 4; out_ready low 5 cycles after out_valid.
  - Required: result = 4, result_idx = 3 held stable throughout.
  - Required: in_ready = 0 during DONE; in_valid pulses in DONE are ignored.
  - Required: the next frame starts cleanly after out_ready.
- Reset mid-frame: accept 250, 251; assert rst_n low for 1 cycle; then send 1, 2, 3, 0 with select = 0.
  - Required: all outputs 0 during reset.
  - Required: result = 3, result_idx = 2.
- Signedness: 8'h80, 8'h7F, 8'h00, 8'h01 with select = 0.
  - Without MMS_SEQ_SIGNED_EN: result = 8'h80, result_idx = 0.
  - With MMS_SEQ_SIGNED_EN: result = 8'h7F, result_idx = 1.

Source files
------------

// File: rtl/mms_pkg.sv
// Shared select encodings and FSM state type for the sequential max/min selector.
package mms_pkg;

  localparam logic SEL_MAX = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } mms_state_e;

endpackage

// File: rtl/mms_cmp_sel.sv
// Compare-and-select: keeps the current best unless the candidate is a strict improvement.
// Comparison is signed when MMS_SEQ_SIGNED_EN is defined, unsigned otherwise.
module mms_cmp_sel
  import mms_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              select,
  input  logic [DATA_W-1:0] cand,
  input  logic [IDX_W-1:0]  cand_idx,
  input  logic [DATA_W-1:0] best,
  input  logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] new_best,
  output logic [IDX_W-1:0]  new_best_idx
);

  logic greater;
  logic less;
  logic improve;

`ifdef MMS_SEQ_SIGNED_EN
  assign greater = $signed(cand) > $signed(best);
  assign less    = $signed(cand) < $signed(best);
`else
  assign greater = cand > best;
  assign less    = cand < best;
`endif

  // Strict comparison so that ties keep the earlier index.
  assign improve = (select == SEL_MIN) ? less : greater;

  always_comb begin
    new_best     = best;
    new_best_idx = best_idx;
    if (improve) begin
      new_best     = cand;
      new_best_idx = cand_idx;
    end
  end

endmodule

// File: rtl/mms_seq.sv
// Streaming max/min selector: one number per cycle in, frame max/min plus its index out.
// Optional build macro MMS_SEQ_SIGNED_EN switches the comparison to two's-complement.
module mms_seq
  import mms_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              select,
  input  logic [DATA_W-1:0] number,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [IDX_W-1:0]  result_idx
);

  mms_state_e        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic              sel_q, sel_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [IDX_W-1:0]  result_idx_q, result_idx_d;

  logic              accept;
  logic              last_num;
  logic [DATA_W-1:0] cmp_best;
  logic [IDX_W-1:0]  cmp_best_idx;

  assign in_ready = (state_q != StDone);
  assign accept   = in_valid && in_ready;
  assign last_num = (cnt_q == IDX_W'(FRAME_LEN - 1));

  mms_cmp_sel #(
    .DATA_W(DATA_W),
    .IDX_W (IDX_W)
  ) u_cmp_sel (
    .select      (sel_q),
    .cand        (number),
    .cand_idx    (cnt_q),
    .best        (best_q),
    .best_idx    (best_idx_q),
    .new_best    (cmp_best),
    .new_best_idx(cmp_best_idx)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    best_idx_d   = best_idx_q;
    sel_d        = sel_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    result_idx_d = result_idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          best_d     = number;
          best_idx_d = '0;
          sel_d      = select;
          cnt_d      = IDX_W'(1);
          state_d    = StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          best_d     = cmp_best;
          best_idx_d = cmp_best_idx;
          if (last_num) begin
            // Publish the post-compare best so the last number can win.
            cnt_d        = '0;
            state_d      = StDone;
            out_valid_d  = 1'b1;
            result_d     = cmp_best;
            result_idx_d = cmp_best_idx;
          end else begin
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = StIdle;
        cnt_d       = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      sel_q        <= SEL_MAX;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      result_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      sel_q        <= sel_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      result_idx_q <= result_idx_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign result_idx = result_idx_q;

endmodule

// File: tb/tb_mms_seq.sv
// Directed self-checking bench for mms_seq; inputs change and outputs are sampled on negedge.
module tb_mms_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       select;
  logic [7:0] number;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [1:0] result_idx;

  int total;
  int bad;

  mms_seq #(
    .DATA_W   (8),
    .FRAME_LEN(4),
    .IDX_W    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .select    (select),
    .number    (number),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_idx(result_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one number for exactly one clock; caller is at a negedge.
  task automatic drive(input logic [7:0] n, input logic s);
    in_valid = 1'b1;
    number   = n;
    select   = s;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if (out_valid !== 1'b0 || result !== 8'd0 || result_idx !== 2'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: ov=%b res=%0d idx=%0d rdy=%b, want ov=0 res=0 idx=0 rdy=1",
               out_valid, result, result_idx, in_ready);
    end
  endtask

  task automatic test_max();
    logic [7:0] v [4];
    v = '{8'd10, 8'd200, 8'd55, 8'd199};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(v[i], 1'b0);
      if (i < 3) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL max_early_valid: after accept %0d ov=%b want 0", i, out_valid);
        end
      end
    end
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 8'd200 || result_idx !== 2'd1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL max_result: ov=%b res=%0d idx=%0d rdy=%b, want ov=1 res=200 idx=1 rdy=0",
               out_valid, result, result_idx, in_ready);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL max_one_cycle: ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_min_tie();
    logic [7:0] v [4];
    v = '{8'd7, 8'd3, 8'd3, 8'd9};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(v[i], 1'b1);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 8'd3 || result_idx !== 2'd1) begin
      bad++;
      $display("FAIL min_tie: ov=%b res=%0d idx=%0d, want ov=1 res=3 idx=1",
               out_valid, result, result_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_select_change();
    out_ready = 1'b1;
    drive(8'd5, 1'b0);
    drive(8'd9, 1'b1);
    drive(8'd2, 1'b1);
    drive(8'd4, 1'b1);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 8'd9 || result_idx !== 2'd1) begin
      bad++;
      $display("FAIL select_change: ov=%b res=%0d idx=%0d, want ov=1 res=9 idx=1",
               out_valid, result, result_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [7:0] v [4];
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(8'(i + 1), 1'b0);
      in_valid = 1'b0;
      if (i < 3) begin
        @(negedge clk);
        @(negedge clk);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL bp_timeout: out_valid=%b after 20 cycles, want 1", out_valid);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      number   = 8'd99;
      select   = 1'b1;
      total++;
      if (out_valid !== 1'b1 || result !== 8'd4 || result_idx !== 2'd3 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold: cyc %0d ov=%b res=%0d idx=%0d rdy=%b, want ov=1 res=4 idx=3 rdy=0",
                 c, out_valid, result, result_idx, in_ready);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: ov=%b rdy=%b, want ov=0 rdy=1", out_valid, in_ready);
    end
    v = '{8'd20, 8'd10, 8'd30, 8'd5};
    for (int i = 0; i < 4; i++) drive(v[i], 1'b1);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 8'd5 || result_idx !== 2'd3) begin
      bad++;
      $display("FAIL bp_next_frame: ov=%b res=%0d idx=%0d, want ov=1 res=5 idx=3",
               out_valid, result, result_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] v [4];
    out_ready = 1'b1;
    drive(8'd250, 1'b0);
    drive(8'd251, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || result !== 8'd0 || result_idx !== 2'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset: ov=%b res=%0d idx=%0d rdy=%b, want ov=0 res=0 idx=0 rdy=1",
               out_valid, result, result_idx, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v = '{8'd1, 8'd2, 8'd3, 8'd0};
    for (int i = 0; i < 4; i++) drive(v[i], 1'b0);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== 8'd3 || result_idx !== 2'd2) begin
      bad++;
      $display("FAIL after_reset: ov=%b res=%0d idx=%0d, want ov=1 res=3 idx=2",
               out_valid, result, result_idx);
    end
    @(negedge clk);
  endtask

  task automatic test_signedness();
    logic [7:0] v [4];
    logic [7:0] exp_res;
    logic [1:0] exp_idx;
`ifdef MMS_SEQ_SIGNED_EN
    exp_res = 8'h7F;
    exp_idx = 2'd1;
`else
    exp_res = 8'h80;
    exp_idx = 2'd0;
`endif
    v = '{8'h80, 8'h7F, 8'h00, 8'h01};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive(v[i], 1'b0);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || result !== exp_res || result_idx !== exp_idx) begin
      bad++;
      $display("FAIL signedness: ov=%b res=%h idx=%0d, want ov=1 res=%h idx=%0d",
               out_valid, result, result_idx, exp_res, exp_idx);
    end
    @(negedge clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    select    = 1'b0;
    number    = 8'd0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_max();
    test_min_tie();
    test_select_change();
    test_backpressure();
    test_reset_mid_frame();
    test_signedness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
